// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: combinational FETCH_NUM-word pack lookup with
// whole-line refill over a req/gnt beat stream. Defining ICACHE_PERF_EN adds hit/miss counters.

module icache_slot #(
  parameter int SLOT       = 0,
  parameter int LINE_WORDS = 8,
  parameter int OFF_W      = 3
) (
  input  logic [OFF_W-1:0]           off,
  input  logic [LINE_WORDS-1:0][31:0] line_a,
  input  logic [LINE_WORDS-1:0][31:0] line_b,
  output logic [31:0]                word
);
  logic [OFF_W:0] pos;

  // pos overflowing past the line end selects the following line
  assign pos  = {1'b0, off} + (OFF_W+1)'(SLOT);
  assign word = pos[OFF_W] ? line_b[pos[OFF_W-1:0]] : line_a[pos[OFF_W-1:0]];
endmodule

module icache #(
  parameter int FETCH_NUM  = 4,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               proc2Icache_addr,
  output logic [32*FETCH_NUM-1:0]   Icache2proc_data,
  output logic                      Icache2proc_data_valid,
  input  logic                      Icache_flush,
  output logic                      Icache2mem_req,
  output logic [31:0]               Icache2mem_addr,
  input  logic                      mem2Icache_gnt,
  input  logic [31:0]               mem2Icache_data,
  input  logic                      mem2Icache_data_valid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]               Icache_hit_cnt,
  output logic [31:0]               Icache_miss_cnt
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int LA_W  = 30 - OFF_W;
  localparam int TAG_W = LA_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
  state_t state, state_n;

  logic [SETS-1:0]                 valid_q;
  logic [TAG_W-1:0]                tag_q  [SETS];
  logic [LINE_WORDS-1:0][31:0]     data_q [SETS];
  logic [LINE_WORDS-1:0][31:0]     fill_buf;
  logic [OFF_W-1:0]                cnt;
  logic                            discard;
  logic [31:0]                     miss_addr;

  logic [LA_W-1:0]  line_a, line_b, miss_line_n;
  logic [IDX_W-1:0] idx_a, idx_b, miss_idx;
  logic [TAG_W-1:0] tag_a, tag_b, miss_tag;
  logic [OFF_W-1:0] off;
  logic             span, hit_a, hit_b, hit, miss_det;
  logic [FETCH_NUM-1:0][31:0] pack;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^proc2Icache_addr[1:0];

  // Line A+1 is a full line-address increment, so the index wrap carries into the tag
  assign line_a = proc2Icache_addr[31 -: LA_W];
  assign line_b = line_a + LA_W'(1);
  assign idx_a  = line_a[IDX_W-1:0];
  assign idx_b  = line_b[IDX_W-1:0];
  assign tag_a  = line_a[LA_W-1 -: TAG_W];
  assign tag_b  = line_b[LA_W-1 -: TAG_W];
  assign off    = proc2Icache_addr[2 +: OFF_W];
  assign span   = ({1'b0, off} + (OFF_W+1)'(FETCH_NUM)) > (OFF_W+1)'(LINE_WORDS);

  assign hit_a       = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign hit_b       = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
  assign hit         = hit_a && (!span || hit_b);
  assign miss_line_n = hit_a ? line_b : line_a;

  assign miss_idx = miss_addr[2+OFF_W +: IDX_W];
  assign miss_tag = miss_addr[31 -: TAG_W];

  genvar g;
  generate
    for (g = 0; g < FETCH_NUM; g++) begin : g_slot
      icache_slot #(.SLOT(g), .LINE_WORDS(LINE_WORDS), .OFF_W(OFF_W)) u_slot (
        .off    (off),
        .line_a (data_q[idx_a]),
        .line_b (data_q[idx_b]),
        .word   (pack[g])
      );
    end
  endgenerate

  assign Icache2proc_data       = pack;
  assign Icache2proc_data_valid = hit && (state == IDLE) && !Icache_flush;
  assign Icache2mem_req         = (state == REQ);
  assign Icache2mem_addr        = miss_addr;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    miss_det = 1'b0;
    case (state)
      IDLE: if (!Icache_flush && !hit) begin
        state_n  = REQ;
        miss_det = 1'b1;
      end
      REQ:  if (mem2Icache_gnt) state_n = FILL;
      FILL: if (mem2Icache_data_valid && cnt == OFF_W'(LINE_WORDS-1)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      cnt       <= '0;
      discard   <= 1'b0;
      miss_addr <= '0;
    end else begin
      if (miss_det) miss_addr <= {miss_line_n, (OFF_W+2)'(0)};
      if (state == REQ && mem2Icache_gnt) cnt <= '0;
      else if (state == FILL && mem2Icache_data_valid) cnt <= cnt + OFF_W'(1);
      if (state == DONE) discard <= 1'b0;
      else if (Icache_flush && state != IDLE) discard <= 1'b1;
      // A flush in DONE wins over the install, leaving the written line invalid
      if (Icache_flush) valid_q <= '0;
      else if (state == DONE && !discard) valid_q[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state == FILL && mem2Icache_data_valid) fill_buf[cnt] <= mem2Icache_data;
    if (state == DONE) begin
      data_q[miss_idx] <= fill_buf;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      Icache_hit_cnt  <= '0;
      Icache_miss_cnt <= '0;
    end else begin
      if (Icache2proc_data_valid) Icache_hit_cnt  <= Icache_hit_cnt + 32'd1;
      if (miss_det)               Icache_miss_cnt <= Icache_miss_cnt + 32'd1;
    end
  end
`endif
endmodule
